// File: rtl/hummingbird_io_pkg.sv
// Shared definitions for the Hummingbird IO UART transmitter:
// register map, FSM encoding and status byte layout.
package hummingbird_io_pkg;

  typedef logic [1:0] io_addr_t;

  localparam io_addr_t ADDR_TXDATA  = 2'd0;
  localparam io_addr_t ADDR_DIVISOR = 2'd1;
  localparam io_addr_t ADDR_CTRL    = 2'd2;
  localparam io_addr_t ADDR_CLRSTAT = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 6;

  localparam logic [7:0] STATUS_RESET = 8'h01;

  function automatic logic [7:0] pack_status(input logic empty, input logic full,
                                             input logic busy, input logic ovf,
                                             input logic [2:0] cnt);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    s[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU IO bus as seen by the UART transmitter: write strobe, address,
// write data and the status byte returned to the CPU input device.
interface io_uart_tx_if;
  import hummingbird_io_pkg::*;

  logic       io_wr;
  io_addr_t   io_addr;
  logic [7:0] io_wdata;
  logic [7:0] status;

  modport master (output io_wr, output io_addr, output io_wdata, input status);
  modport slave  (input io_wr, input io_addr, input io_wdata, output status);
endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO with first-word fall-through read; DEPTH must be a power of two
// so the pointers wrap naturally.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a small FIFO,
// the FSM serialises them at a programmable baud divisor.
module io_uart_tx
  import hummingbird_io_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = 8'd103
) (
  input  logic  clk,
  input  logic  rst,
  io_uart_tx_if.slave bus,
  output logic  txd,
  output logic  busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state_r, state_nxt_s;
  logic [7:0]    divisor_r, div_lat_r, div_lat_nxt_s;
  logic [7:0]    baud_r, baud_nxt_s, shift_r, shift_nxt_s;
  logic [2:0]    bit_r, bit_nxt_s;
  logic          txd_r, txd_nxt_s, busy_r, enable_r, ovf_r;
  logic [7:0]    status_r;
  logic          pop_s, push_s, wr_tx_s, ovf_set_s, bit_end_s, start_ok_s;
  logic [7:0]    fifo_rdata_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [2:0]    cnt3_s;

  assign wr_tx_s    = bus.io_wr && (bus.io_addr == ADDR_TXDATA);
  // A full FIFO still accepts a write when the FSM pops in the same cycle.
  assign push_s     = wr_tx_s && (!fifo_full_s || pop_s);
  assign ovf_set_s  = wr_tx_s && fifo_full_s && !pop_s;
  assign start_ok_s = enable_r && !fifo_empty_s;
  assign bit_end_s  = (baud_r == div_lat_r);
  assign cnt3_s     = 3'(fifo_count_s);

  assign txd        = txd_r;
  assign busy       = busy_r;
  assign bus.status = status_r;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus.io_wdata),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Frame sequencer: next state, bit timing and the serial bit to drive.
  always_comb begin
    state_nxt_s   = state_r;
    baud_nxt_s    = baud_r;
    bit_nxt_s     = bit_r;
    shift_nxt_s   = shift_r;
    div_lat_nxt_s = div_lat_r;
    txd_nxt_s     = txd_r;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        txd_nxt_s = 1'b1;
        if (start_ok_s) begin
          pop_s         = 1'b1;
          state_nxt_s   = ST_START;
          shift_nxt_s   = fifo_rdata_s;
          div_lat_nxt_s = divisor_r;
          baud_nxt_s    = 8'd0;
          txd_nxt_s     = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt_s = ST_DATA;
          baud_nxt_s  = 8'd0;
          bit_nxt_s   = 3'd0;
          txd_nxt_s   = shift_r[0];
        end else begin
          baud_nxt_s = baud_r + 8'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_nxt_s = 8'd0;
          if (bit_r == 3'd7) begin
            state_nxt_s = ST_STOP;
            txd_nxt_s   = 1'b1;
          end else begin
            bit_nxt_s   = bit_r + 3'd1;
            shift_nxt_s = {1'b0, shift_r[7:1]};
            txd_nxt_s   = shift_r[1];
          end
        end else begin
          baud_nxt_s = baud_r + 8'd1;
        end
      end
      ST_STOP: begin
        if (!bit_end_s) begin
          baud_nxt_s = baud_r + 8'd1;
        end else if (start_ok_s) begin
          // Back-to-back frame: the next start bit follows the stop bit directly.
          pop_s         = 1'b1;
          state_nxt_s   = ST_START;
          shift_nxt_s   = fifo_rdata_s;
          div_lat_nxt_s = divisor_r;
          baud_nxt_s    = 8'd0;
          txd_nxt_s     = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
          baud_nxt_s  = 8'd0;
          txd_nxt_s   = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = 8'd0;
        txd_nxt_s   = 1'b1;
      end
    endcase
  end

  // CPU-visible registers: divisor, enable, sticky overflow and status byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_r <= DIV_RESET;
      enable_r  <= 1'b1;
      ovf_r     <= 1'b0;
      status_r  <= STATUS_RESET;
    end else begin
      if (bus.io_wr && (bus.io_addr == ADDR_DIVISOR)) divisor_r <= bus.io_wdata;
      if (bus.io_wr && (bus.io_addr == ADDR_CTRL))    enable_r  <= bus.io_wdata[0];
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (bus.io_wr && (bus.io_addr == ADDR_CLRSTAT)) begin
        ovf_r <= 1'b0;
      end
      status_r <= pack_status(fifo_empty_s, fifo_full_s, state_r != ST_IDLE,
                              ovf_r, cnt3_s);
    end
  end

  // Transmit datapath and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      baud_r    <= 8'd0;
      bit_r     <= 3'd0;
      shift_r   <= 8'd0;
      div_lat_r <= DIV_RESET;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      baud_r    <= baud_nxt_s;
      bit_r     <= bit_nxt_s;
      shift_r   <= shift_nxt_s;
      div_lat_r <= div_lat_nxt_s;
      txd_r     <= txd_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: frame shape and timing, FIFO full/overflow
// behaviour, divisor latching, enable clearing and reset.
module tb_io_uart_tx;
  import hummingbird_io_pkg::*;

  logic clk;
  logic rst;
  logic txd;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  io_uart_tx_if bus_if ();

  io_uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(8'd103)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if),
    .txd  (txd),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at cycle i of a frame carrying byte b with blen-cycle bits.
  function automatic logic exp_bit(input logic [7:0] b, input int i, input int blen);
    int k;
    k = i / blen;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  // Called at a negedge; the write is taken at the following posedge.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus_if.io_wr    = 1'b1;
    bus_if.io_addr  = a;
    bus_if.io_wdata = d;
    @(negedge clk);
    bus_if.io_wr    = 1'b0;
  endtask

  task automatic apply_reset();
    bus_if.io_wr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus_if.status !== 8'h01) begin errors++; $display("FAIL reset_status: got %h expected 01", bus_if.status); end
    rst = 1'b1;
    bus_if.io_wr = 1'b1; bus_if.io_addr = ADDR_TXDATA; bus_if.io_wdata = 8'h33;
    @(negedge clk);
    rst = 1'b0; bus_if.io_wr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.status !== 8'h01) begin errors++; $display("FAIL reset_prio_status: got %h expected 01", bus_if.status); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_prio_txd: got %b expected 1", txd); end
  endtask

  task automatic test_basic_frame();
    cpu_write(ADDR_DIVISOR, 8'd0);
    cpu_write(ADDR_TXDATA, 8'hA5);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL latency_early: got %b expected 1", txd); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== exp_bit(8'hA5, i, 1)) begin
        errors++; $display("FAIL basic_txd[%0d]: got %b expected %b", i, txd, exp_bit(8'hA5, i, 1));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic e;
    cpu_write(ADDR_DIVISOR, 8'd2);
    cpu_write(ADDR_TXDATA, 8'h01);
    cpu_write(ADDR_TXDATA, 8'h80);
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      e = (i < 30) ? exp_bit(8'h01, i, 3) : exp_bit(8'h80, i - 30, 3);
      checks++;
      if (txd !== e) begin errors++; $display("FAIL b2b_txd[%0d]: got %b expected %b", i, txd, e); end
      if (i > 0) begin
        checks++;
        if (bus_if.status[2] !== 1'b1) begin
          errors++; $display("FAIL b2b_status_busy[%0d]: got %b expected 1", i, bus_if.status[2]);
        end
      end
    end
    @(negedge clk);
    checks++; if (bus_if.status[2] !== 1'b1) begin errors++; $display("FAIL b2b_status_last: got %b expected 1", bus_if.status[2]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_overflow_and_disable();
    int n;
    int bad;
    cpu_write(ADDR_CTRL, 8'h00);
    for (int i = 0; i < 5; i++) cpu_write(ADDR_TXDATA, 8'(8'h10 + i));
    @(negedge clk);
    checks++; if (bus_if.status !== 8'h4A) begin errors++; $display("FAIL ovf_status: got %h expected 4a", bus_if.status); end
    cpu_write(ADDR_CLRSTAT, 8'h00);
    @(negedge clk);
    checks++; if (bus_if.status !== 8'h42) begin errors++; $display("FAIL clrstat_status: got %h expected 42", bus_if.status); end
    // Enable, then clear enable mid-frame: the frame completes, nothing follows.
    cpu_write(ADDR_CTRL, 8'h01);
    repeat (5) @(negedge clk);
    cpu_write(ADDR_CTRL, 8'h00);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL disable_busy_mid: got %b expected 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 25) begin errors++; $display("FAIL disable_frame_end: got %0d cycles expected 25", n); end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL disable_no_new_frame: got %0d active cycles expected 0", bad); end
    checks++; if (bus_if.status !== 8'h30) begin errors++; $display("FAIL disable_status: got %h expected 30", bus_if.status); end
  endtask

  task automatic test_divisor_change();
    logic e;
    apply_reset();
    cpu_write(ADDR_DIVISOR, 8'd3);
    cpu_write(ADDR_TXDATA, 8'h55);
    cpu_write(ADDR_TXDATA, 8'h0F);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL div_txd[0]: got %b expected 0", txd); end
    cpu_write(ADDR_DIVISOR, 8'd7);
    for (int i = 1; i < 120; i++) begin
      if (i > 1) @(negedge clk);
      e = (i < 40) ? exp_bit(8'h55, i, 4) : exp_bit(8'h0F, i - 40, 8);
      checks++;
      if (txd !== e) begin errors++; $display("FAIL div_txd[%0d]: got %b expected %b", i, txd, e); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    cpu_write(ADDR_DIVISOR, 8'd3);
    cpu_write(ADDR_TXDATA, 8'h11);
    cpu_write(ADDR_TXDATA, 8'h22);
    cpu_write(ADDR_TXDATA, 8'h33);
    cpu_write(ADDR_TXDATA, 8'h44);
    repeat (10) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midrst_pre_txd: got %b expected 0", txd); end
    checks++; if (bus_if.status !== 8'h34) begin errors++; $display("FAIL midrst_pre_status: got %h expected 34", bus_if.status); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b expected 1", txd); end
    checks++; if (bus_if.status !== 8'h01) begin errors++; $display("FAIL midrst_status: got %h expected 01", bus_if.status); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_frame: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    cpu_write(ADDR_CTRL, 8'h00);
    for (int i = 0; i < 4; i++) cpu_write(ADDR_TXDATA, 8'(8'hA1 + i));
    @(negedge clk);
    checks++; if (bus_if.status !== 8'h42) begin errors++; $display("FAIL fullpop_pre: got %h expected 42", bus_if.status); end
    cpu_write(ADDR_CTRL, 8'h01);
    cpu_write(ADDR_TXDATA, 8'hEE);
    @(negedge clk);
    checks++; if (bus_if.status !== 8'h46) begin errors++; $display("FAIL fullpop_status: got %h expected 46", bus_if.status); end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL fullpop_start: got %b expected 0", txd); end
    apply_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus_if.io_wr    = 1'b0;
    bus_if.io_addr  = 2'd0;
    bus_if.io_wdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_overflow_and_disable();
    test_divisor_change();
    test_reset_mid_frame();
    test_full_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
